// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder exposing four read/write registers.
// The write path collects AW and W independently (either order or together),
// commits on the edge where both are held, and then answers on B. The read
// path is a separate two-state FSM returning the pre-edge register value on R.
// Register contents and a one-cycle write strobe per register are exported.
module axi_lite_slave_regs #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic [DATA_WIDTH-1:0] slv_reg0,
   output logic [DATA_WIDTH-1:0] slv_reg1,
   output logic [DATA_WIDTH-1:0] slv_reg2,
   output logic [DATA_WIDTH-1:0] slv_reg3,
   output logic [3:0]            reg_wr_pulse
);

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic                  aw_held, w_held;
   logic [1:0]            aw_idx_hold;
   logic [DATA_WIDTH-1:0] w_data_hold;
   logic                  aw_hs, w_hs, wr_commit, ar_hs;
   logic [1:0]            wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] regs [4];

   // Byte-lane bits of the addresses never select anything.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

   // Every address decodes to a register, so responses are always OKAY.
   assign BRESP = 2'b00;
   assign RRESP = 2'b00;

   assign slv_reg0 = regs[0];
   assign slv_reg1 = regs[1];
   assign slv_reg2 = regs[2];
   assign slv_reg3 = regs[3];

   // Write FSM next state, READY decode and commit detection.
   always_comb begin
      w_state_nxt = w_state;
      AWREADY     = 1'b0;
      WREADY      = 1'b0;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      wr_commit   = 1'b0;
      wr_idx      = aw_held ? aw_idx_hold : AWADDR[3:2];
      wr_data     = w_held  ? w_data_hold : WDATA;
      case (w_state)
         W_IDLE: begin
            AWREADY   = ~aw_held & ~ARESET;
            WREADY    = ~w_held & ~ARESET;
            aw_hs     = AWVALID & AWREADY;
            w_hs      = WVALID & WREADY;
            wr_commit = (aw_held | aw_hs) & (w_held | w_hs);
            if (wr_commit) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            if (BVALID && BREADY) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write FSM state register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) w_state <= W_IDLE;
      else        w_state <= w_state_nxt;
   end

   // Held flags: set on each handshake, cleared together on commit.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else if (wr_commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_hs) aw_held <= 1'b1;
         if (w_hs)  w_held  <= 1'b1;
      end
   end

   // Holding registers for whichever half of the write arrived first.
   always_ff @(posedge ACLK) begin
      if (aw_hs) aw_idx_hold <= AWADDR[3:2];
      if (w_hs)  w_data_hold <= WDATA;
   end

   // Write response valid: raised on commit, dropped on the B handshake.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)                BVALID <= 1'b0;
      else if (wr_commit)        BVALID <= 1'b1;
      else if (BVALID && BREADY) BVALID <= 1'b0;
   end

   // Register file update and one-cycle per-register write strobe.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < 4; i++) regs[i] <= RESET_VALUE;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (wr_commit) begin
            regs[wr_idx]         <= wr_data;
            reg_wr_pulse[wr_idx] <= 1'b1;
         end
      end
   end

   // Read FSM next state and ARREADY decode.
   always_comb begin
      r_state_nxt = r_state;
      ARREADY     = 1'b0;
      ar_hs       = 1'b0;
      case (r_state)
         R_IDLE: begin
            ARREADY = ~ARESET;
            ar_hs   = ARVALID & ARREADY;
            if (ar_hs) r_state_nxt = R_RESP;
         end
         R_RESP: begin
            if (RVALID && RREADY) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read FSM state register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_state <= R_IDLE;
      else        r_state <= r_state_nxt;
   end

   // Read data capture (pre-edge register value) and RVALID handshake.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         RDATA  <= '0;
         RVALID <= 1'b0;
      end else if (ar_hs) begin
         RDATA  <= regs[ARADDR[3:2]];
         RVALID <= 1'b1;
      end else if (RVALID && RREADY) begin
         RVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Randomized self-checking bench for axi_lite_slave_regs with a
// transaction-level register model.
module tb_axi_lite_slave_regs;

   localparam logic [31:0] RV = 32'h5A00_00F1;

   logic        ACLK, ARESET;
   logic [3:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [1:0]  BRESP, RRESP;
   logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
   logic [3:0]  reg_wr_pulse;

   logic [31:0] mdl [4];
   int          n_checks = 0;
   int          n_pass   = 0;

   axi_lite_slave_regs #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (4),
      .RESET_VALUE (RV)
   ) dut (
      .ACLK         (ACLK),
      .ARESET       (ARESET),
      .AWADDR       (AWADDR),
      .AWVALID      (AWVALID),
      .AWREADY      (AWREADY),
      .WDATA        (WDATA),
      .WVALID       (WVALID),
      .WREADY       (WREADY),
      .BRESP        (BRESP),
      .BVALID       (BVALID),
      .BREADY       (BREADY),
      .ARADDR       (ARADDR),
      .ARVALID      (ARVALID),
      .ARREADY      (ARREADY),
      .RDATA        (RDATA),
      .RRESP        (RRESP),
      .RVALID       (RVALID),
      .RREADY       (RREADY),
      .slv_reg0     (slv_reg0),
      .slv_reg1     (slv_reg1),
      .slv_reg2     (slv_reg2),
      .slv_reg3     (slv_reg3),
      .reg_wr_pulse (reg_wr_pulse)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] slv(input int i);
      case (i)
         0:       return slv_reg0;
         1:       return slv_reg1;
         2:       return slv_reg2;
         default: return slv_reg3;
      endcase
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Full write: AW after aw_dly cycles, W after w_dly cycles, BREADY after
   // b_dly cycles of BVALID. With poke, a junk AW/W is offered during the
   // response phase and then withdrawn.
   task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly, input bit poke);
      bit aw_done = 0;
      bit w_done  = 0;
      bit hs_aw, hs_w;
      int c = 0;
      int idx = int'(addr[3:2]);
      while (!(aw_done && w_done) && c < 50) begin
         AWADDR  = addr;
         WDATA   = data;
         AWVALID = !aw_done && (c >= aw_dly);
         WVALID  = !w_done && (c >= w_dly);
         chk("awready_idle", 32'(AWREADY), 32'(!aw_done));
         chk("wready_idle", 32'(WREADY), 32'(!w_done));
         chk("bvalid_idle", 32'(BVALID), 32'd0);
         hs_aw = AWVALID && AWREADY;
         hs_w  = WVALID && WREADY;
         tick();
         if (hs_aw) aw_done = 1;
         if (hs_w)  w_done  = 1;
         c++;
      end
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      if (!(aw_done && w_done)) begin
         chk("wr_timeout", 32'd0, 32'd1);
         return;
      end
      mdl[idx] = data;
      chk("bvalid_set", 32'(BVALID), 32'd1);
      chk("bresp", 32'(BRESP), 32'd0);
      chk("wr_pulse", 32'(reg_wr_pulse), 32'd1 << idx);
      chk("slv_reg", slv(idx), data);
      for (int k = 0; k < b_dly; k++) begin
         if (poke) begin
            AWVALID = 1'b1;
            WVALID  = 1'b1;
            AWADDR  = 4'($urandom_range(0, 15));
            WDATA   = $urandom;
         end
         chk("bvalid_hold", 32'(BVALID), 32'd1);
         chk("awready_resp", 32'(AWREADY), 32'd0);
         chk("wready_resp", 32'(WREADY), 32'd0);
         tick();
      end
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      BREADY  = 1'b1;
      chk("bvalid_pre", 32'(BVALID), 32'd1);
      tick();
      BREADY = 1'b0;
      chk("bvalid_clr", 32'(BVALID), 32'd0);
      chk("pulse_clr", 32'(reg_wr_pulse), 32'd0);
      chk("awready_back", 32'(AWREADY), 32'd1);
      chk("wready_back", 32'(WREADY), 32'd1);
   endtask

   // Full read with RREADY held low for r_dly cycles.
   task automatic do_read(input logic [3:0] addr, input int r_dly);
      logic [31:0] exp;
      exp     = mdl[int'(addr[3:2])];
      ARADDR  = addr;
      ARVALID = 1'b1;
      chk("arready", 32'(ARREADY), 32'd1);
      tick();
      ARVALID = 1'b0;
      ARADDR  = 4'($urandom_range(0, 15));
      chk("rvalid_set", 32'(RVALID), 32'd1);
      chk("rdata", RDATA, exp);
      chk("rresp", 32'(RRESP), 32'd0);
      for (int k = 0; k < r_dly; k++) begin
         chk("arready_resp", 32'(ARREADY), 32'd0);
         tick();
         chk("rvalid_hold", 32'(RVALID), 32'd1);
         chk("rdata_hold", RDATA, exp);
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      chk("rvalid_clr", 32'(RVALID), 32'd0);
      chk("arready_back", 32'(ARREADY), 32'd1);
   endtask

   initial begin
      logic [31:0] old;
      ARESET = 1'b1;
      AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = RV;
      repeat (2) tick();

      chk("rst_awready", 32'(AWREADY), 32'd0);
      chk("rst_wready", 32'(WREADY), 32'd0);
      chk("rst_arready", 32'(ARREADY), 32'd0);
      chk("rst_bvalid", 32'(BVALID), 32'd0);
      chk("rst_rvalid", 32'(RVALID), 32'd0);
      chk("rst_rdata", RDATA, 32'd0);
      chk("rst_pulse", 32'(reg_wr_pulse), 32'd0);
      for (int i = 0; i < 4; i++) chk("rst_reg", slv(i), RV);
      ARESET = 1'b0;
      tick();

      // Directed scenarios.
      do_write(4'h4, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
      do_write(4'hC, 32'h1234_5678, 3, 0, 0, 1'b0);
      do_write(4'h8, 32'hA5A5_A5A5, 0, 0, 5, 1'b1);
      do_read(4'h8, 4);
      do_read(4'h4, 0);

      // Write and read the same register on the same edge.
      old     = mdl[0];
      AWADDR  = 4'h0; WDATA = 32'h0000_0001; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR  = 4'h3; ARVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      chk("col_rdata", RDATA, old);
      chk("col_rvalid", 32'(RVALID), 32'd1);
      chk("col_bvalid", 32'(BVALID), 32'd1);
      mdl[0] = 32'h0000_0001;
      chk("col_reg", slv(0), 32'h0000_0001);
      BREADY = 1'b1; RREADY = 1'b1;
      tick();
      BREADY = 1'b0; RREADY = 1'b0;
      chk("col_bvalid_clr", 32'(BVALID), 32'd0);
      chk("col_rvalid_clr", 32'(RVALID), 32'd0);
      do_read(4'h1, 0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1)
            do_write(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         else
            do_read(4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end

      // Asynchronous reset with AW accepted and W still pending.
      AWADDR = 4'h4; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      chk("t6_aw_held", 32'(AWREADY), 32'd0);
      chk("t6_w_open", 32'(WREADY), 32'd1);
      #2;
      ARESET = 1'b1;
      #1;
      chk("t6_awready", 32'(AWREADY), 32'd0);
      chk("t6_wready", 32'(WREADY), 32'd0);
      chk("t6_arready", 32'(ARREADY), 32'd0);
      chk("t6_bvalid", 32'(BVALID), 32'd0);
      chk("t6_rvalid", 32'(RVALID), 32'd0);
      for (int i = 0; i < 4; i++) begin
         mdl[i] = RV;
         chk("t6_reg", slv(i), RV);
      end
      tick();
      ARESET = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6_no_bvalid", 32'(BVALID), 32'd0);
         chk("t6_awready_free", 32'(AWREADY), 32'd1);
         chk("t6_wready_free", 32'(WREADY), 32'd1);
      end
      do_write(4'h6, 32'hCAFE_F00D, 1, 0, 1, 1'b0);
      do_read(4'h5, 1);
      do_read(4'hE, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder with four 32-bit read/write registers. It terminates the write channels (AW, W, B) and the read channels (AR, R) driven by the team's AXI-Lite master. Register contents are exported to downstream logic, together with a one-cycle write strobe per register. The write and read paths are independent and may be active in the same cycle.

Parameters:
DATA_WIDTH, 32, register and bus data width
ADDR_WIDTH, 4, byte address width; word index = addr[3:2]
RESET_VALUE, 32'h0000_0000, reset contents of every register

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESET  input  1  reset, asynchronous, active-high
AWADDR  input  ADDR_WIDTH  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  DATA_WIDTH  write data
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BRESP  output  2  write response, always 2'b00 (OKAY)
BVALID  output  1  write response valid
BREADY  input  1  write response ready
ARADDR  input  ADDR_WIDTH  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  DATA_WIDTH  read data
RRESP  output  2  read response, always 2'b00 (OKAY)
RVALID  output  1  read data valid
RREADY  input  1  read data ready
slv_reg0..slv_reg3  output  DATA_WIDTH each  current register contents
reg_wr_pulse  output  4  one-hot, high for 1 cycle after register i is written

Behaviour:
- Reset (ARESET=1, asynchronous):
  - AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0.
  - BRESP=0, RRESP=0, RDATA=0, reg_wr_pulse=0.
  - slv_reg0..3=RESET_VALUE; all FSMs return to IDLE.
  - Reset mid-transaction drops it silently: no BVALID/RVALID afterwards, no register write.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AWREADY=~aw_held, WREADY=~w_held (combinational from the held flags). AW and W are accepted independently, in either order or in the same cycle.
  - On each handshake, latch AWADDR or WDATA into a holding register and set the matching held flag.
  - The edge on which both are held (including both arriving on the same edge) does all of the following: writes slv_reg[addr[3:2]]=data, sets reg_wr_pulse[addr[3:2]] for the next cycle, sets BVALID=1, clears both held flags, and moves to W_RESP.
  - W_RESP: AWREADY=WREADY=0. BVALID stays high until BVALID&BREADY, then return to W_IDLE with BVALID=0 on that edge.
  - BREADY already high when BVALID rises: one-cycle B phase.
  - Minimum back-to-back write spacing is 2 cycles (accept, respond).
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY=1.
  - On ARVALID&ARREADY: RDATA<=slv_reg[ARADDR[3:2]] (pre-edge value), RVALID<=1, move to R_RESP.
  - R_RESP: ARREADY=0. RDATA and RVALID are held stable until RVALID&RREADY, then RVALID<=0 and return to R_IDLE.
- Address rules: addr[1:0] are ignored. All 16 byte addresses decode to a valid register, so the response is always OKAY.
- Read/write collision: if a write commits to register i on the same edge as an AR handshake to register i, RDATA returns the old value. A later read returns the new value.
- VALID inputs deasserting without a handshake must not corrupt the held flags.
- All outputs are registered except AWREADY, WREADY and ARREADY, which are decoded from state and flags.

Test Plan:
1. Reset, then AWADDR=4'h4, WDATA=32'hDEAD_BEEF, AWVALID=WVALID=1 in one cycle, BREADY=1 -> BVALID for 1 cycle with BRESP=0; slv_reg1=DEADBEEF; reg_wr_pulse=4'b0010 for 1 cycle.
2. WVALID (data 32'h1234_5678) 3 cycles before AWVALID (addr 4'hC) -> WREADY drops after the W handshake, AWREADY stays 1 until the AW handshake; slv_reg3=12345678; exactly one BVALID.
3. Write slv_reg2=32'hA5A5_A5A5, hold BREADY=0 for 5 cycles -> BVALID stays high and AWREADY=WREADY=0 throughout; a second AW/W is accepted only after BREADY.
4. ARADDR=4'h8 with RREADY=0 for 4 cycles -> RVALID=1 and RDATA=A5A5A5A5 held stable; RVALID drops on the edge RREADY=1.
5. Same cycle: write 32'h0000_0001 to 4'h0 and read 4'h0 (previously 0) -> RDATA=0; a following read gives RDATA=1.
6. Assert ARESET asynchronously with AW accepted but W pending -> all READY/VALID outputs 0 immediately; registers=RESET_VALUE; no BVALID after release.
